// File: rtl/mem_access_unit.sv
// Memory-stage access unit: variable-latency bus master with lane
// steering, load extension, address checks and bus timeout.
module mem_access_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_7FFF,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_m,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic                flush,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                stall,
  output logic [DATA_W-1:0]   rdata_w,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic                bus_req,
  output logic                bus_we,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned BEW = DATA_W / 8;
  localparam int unsigned OW  = $clog2(BEW);
  localparam int unsigned IW  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       baddr_q, baddr_d;
  logic [BEW-1:0]    be_q, be_d;
  logic [DATA_W-1:0] bwd_q, bwd_d;
  logic [DATA_W-1:0] rdw_q, rdw_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [OW-1:0]     off_q, off_d;
  logic              disc_q, disc_d;
  logic              dbe_q, dbe_d;

  logic              req, ri, misal, in_rng, err, disc_now;
  logic [4:0]        err_code;
  logic [OW-1:0]     off;
  logic [31:0]       amask, rng_off;
  logic [15:0]       be_m, be_sh;
  logic [DATA_W-1:0] wd_sh, rd_sh, fmask, rd_ext;
  logic [7:0]        nbits, msb_i;
  logic              msb;

  assign req = valid_m & (mem_rd | mem_wr) & ~flush;
  assign off = addr[OW-1:0];

  always_comb begin
    amask    = (32'd1 << size) - 32'd1;
    misal    = |(addr & amask);
    rng_off  = addr - ADDR_LO;
    in_rng   = rng_off <= (ADDR_HI - ADDR_LO);
    ri       = (size == 2'd3) && (DATA_W == 32);
    err      = req & (ri | misal | ~in_rng);
    err_code = ri ? 5'd10 : (mem_rd ? 5'd4 : 5'd5);
    be_m     = (16'd1 << (5'd1 << size)) - 16'd1;
    be_sh    = be_m << off;
    wd_sh    = wdata << {off, 3'b000};
  end

  // Load field extraction from the lane latched at accept time
  always_comb begin
    rd_sh  = bus_rdata >> {off_q, 3'b000};
    nbits  = 8'd8 << size_q;
    msb_i  = nbits - 8'd1;
    msb    = rd_sh[msb_i[IW-1:0]];
    fmask  = (DATA_W'(1) << nbits) - DATA_W'(1);
    if (sext_q && (size_q < 2'd2) && msb)
      rd_ext = rd_sh | ~fmask;
    else
      rd_ext = rd_sh & fmask;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    baddr_d   = baddr_q;
    be_d      = be_q;
    bwd_d     = bwd_q;
    rdw_d     = rdw_q;
    size_d    = size_q;
    sext_d    = sext_q;
    off_d     = off_q;
    disc_d    = disc_q;
    dbe_d     = dbe_q;
    disc_now  = disc_q | flush;
    stall     = 1'b0;
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (err) begin
          exc_valid = 1'b1;
          exc_code  = err_code;
        end else if (req) begin
          stall   = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = ~mem_rd;
          baddr_d = {addr[31:OW], {OW{1'b0}}};
          be_d    = be_sh[BEW-1:0];
          bwd_d   = wd_sh;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = off;
          disc_d  = 1'b0;
          dbe_d   = 1'b0;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        disc_d = disc_now;
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q && !disc_now)
            rdw_d = rd_ext;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          dbe_d   = ~disc_now;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        if (dbe_q) begin
          exc_valid = 1'b1;
          exc_code  = 5'd7;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      stall     = 1'b0;
      exc_valid = 1'b0;
      exc_code  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= 32'd0;
      be_q    <= '0;
      bwd_q   <= '0;
      rdw_q   <= '0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      off_q   <= '0;
      disc_q  <= 1'b0;
      dbe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      bwd_q   <= bwd_d;
      rdw_q   <= rdw_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      disc_q  <= disc_d;
      dbe_q   <= dbe_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwd_q;
  assign rdata_w   = rdw_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses
// checked against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 0;
  logic        reset;
  logic        valid_m, mem_rd, mem_wr, sign_ext, flush;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, exc_valid, bus_req, bus_we, bus_ack;
  logic [31:0] rdata_w, bus_addr, bus_wdata, bus_rdata;
  logic [4:0]  exc_code;
  logic [3:0]  bus_be;

  logic        v64, rd64, sx64, ack64, st64, ev64, req64, we64;
  logic [1:0]  sz64;
  logic [31:0] a64, ba64;
  logic [63:0] wd64, rdw64, bwd64, rdat64;
  logic [4:0]  ec64;
  logic [7:0]  be64;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_rdata = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .size(size), .sign_ext(sign_ext), .flush(flush),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata_w(rdata_w),
    .exc_valid(exc_valid), .exc_code(exc_code), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.DATA_W(64), .TIMEOUT_CYC(TMO)) dut64 (
    .clk(clk), .reset(reset), .valid_m(v64), .mem_rd(rd64),
    .mem_wr(1'b0), .size(sz64), .sign_ext(sx64), .flush(1'b0),
    .addr(a64), .wdata(wd64), .stall(st64), .rdata_w(rdw64),
    .exc_valid(ev64), .exc_code(ec64), .bus_req(req64),
    .bus_we(we64), .bus_addr(ba64), .bus_be(be64),
    .bus_wdata(bwd64), .bus_ack(ack64), .bus_rdata(rdat64)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One M-stage access. ack_n: BUSY cycle carrying bus_ack (0 = never).
  // flush_at: BUSY cycle with flush high (0 = none).
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_n,
                        input int flush_at, input logic [31:0] rdv);
    int          off;
    int          nb;
    bit          ri, bad, disc, acked;
    logic [63:0] f, mask;
    logic [31:0] ebe, ewd;
    off   = int'(a % 4);
    ri    = (sz == 2'd3);
    bad   = ri || ((a % (32'd1 << sz)) != 0) || (a > 32'h7FFF);
    disc  = 0;
    acked = 0;
    ebe   = ((32'd1 << (1 << sz)) - 1) << off;
    ewd   = wd << (8 * off);
    @(negedge clk);
    valid_m = 1; mem_rd = rd; mem_wr = wr; size = sz;
    sign_ext = sx; addr = a; wdata = wd; flush = 0;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    #1;
    if (bad) begin
      chk("exc_v", exc_valid, 1);
      chk("exc_code", exc_code, ri ? 10 : (rd ? 4 : 5));
      chk("stall_err", stall, 0);
      chk("req_err", bus_req, 0);
      @(negedge clk);
      valid_m = 0; bus_ack = 0;
      #1;
      chk("no_req", bus_req, 0);
      chk("no_exc", exc_valid, 0);
      return;
    end
    chk("stall_acc", stall, 1);
    chk("exc_acc", exc_valid, 0);
    chk("req_acc", bus_req, 0);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      bus_ack = (k == ack_n);
      flush = (k == flush_at);
      bus_rdata = rdv;
      #1;
      chk("busy_req", bus_req, 1);
      chk("busy_stall", stall, 1);
      chk("busy_exc", exc_valid, 0);
      if (k == 1) begin
        chk("bus_we", bus_we, !rd);
        chk("bus_addr", bus_addr, a & ~32'd3);
        chk("bus_be", bus_be, ebe);
        chk("bus_wdata", bus_wdata, ewd);
      end
      if (flush) disc = 1;
      if (k == ack_n) begin
        acked = 1;
        break;
      end
    end
    if (rd && acked && !disc) begin
      nb   = 8 << sz;
      f    = 64'(rdv) >> (8 * off);
      mask = (64'd1 << nb) - 1;
      f    = f & mask;
      if (sx && sz < 2 && f[nb-1]) f = f | ~mask;
      m_rdata = f[31:0];
    end
    @(negedge clk);
    bus_ack = 1'($urandom_range(0, 1));
    flush = 0; bus_rdata = $urandom;
    #1;
    chk("done_stall", stall, 0);
    chk("done_req", bus_req, 0);
    chk("done_exc", exc_valid, !acked && !disc);
    if (!acked && !disc) chk("done_code", exc_code, 7);
    chk("rdata_w", rdata_w, m_rdata);
  endtask

  task automatic acc64(input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [63:0] rv,
                       input logic [7:0] ebe, input logic [63:0] erd);
    @(negedge clk);
    v64 = 1; rd64 = 1; sz64 = sz; sx64 = sx; a64 = a; ack64 = 0;
    #1 chk("d64_stall", st64, 1);
    @(negedge clk);
    ack64 = 1; rdat64 = rv;
    #1;
    chk("d64_req", req64, 1);
    chk("d64_be", be64, ebe);
    chk("d64_addr", ba64, {a[31:3], 3'b000});
    @(negedge clk);
    ack64 = 0; v64 = 0;
    #1;
    chk("d64_rdata", rdw64, erd);
    chk("d64_stall_done", st64, 0);
    chk("d64_exc", ev64, 0);
  endtask

  initial begin
    bit          rd, wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          an, fa, sel;
    reset = 1; valid_m = 0; mem_rd = 0; mem_wr = 0; size = 0;
    sign_ext = 0; flush = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    v64 = 0; rd64 = 0; sx64 = 0; sz64 = 0; a64 = 0; wd64 = 0;
    ack64 = 0; rdat64 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata_w, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_code", exc_code, 0);
    @(negedge clk);
    reset = 0;

    access(1, 0, 2, 0, 32'h10, 0, 1, 0, 32'hDEAD_BEEF);
    chk("lw_lit", rdata_w, 32'hDEAD_BEEF);
    access(1, 0, 0, 1, 32'h13, 0, 1, 0, 32'h80FF_FF7F);
    chk("lb_lit", rdata_w, 32'hFFFF_FF80);
    access(1, 0, 0, 0, 32'h13, 0, 1, 0, 32'h80FF_FF7F);
    chk("lbu_lit", rdata_w, 32'h0000_0080);
    access(0, 1, 1, 0, 32'h22, 32'h0000_1234, 5, 0, 0);
    access(1, 0, 1, 0, 32'h11, 0, 1, 0, 0);
    access(0, 1, 2, 0, 32'h8000, 0, 1, 0, 0);
    access(1, 0, 3, 0, 32'h0, 0, 1, 0, 0);
    access(1, 0, 2, 0, 32'h40, 0, 0, 0, 0);
    access(1, 1, 1, 1, 32'h2E, 0, 16, 0, 32'hBEEF_1234);
    access(1, 0, 2, 0, 32'h44, 0, 3, 2, 32'h1111_2222);
    access(1, 0, 2, 0, 32'h48, 0, 0, 5, 0);

    // flush blocks acceptance in IDLE
    @(negedge clk);
    valid_m = 1; mem_rd = 1; mem_wr = 0; size = 2; addr = 32'h11;
    flush = 1; bus_ack = 0;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_exc", exc_valid, 0);
    @(negedge clk);
    valid_m = 0; flush = 0;
    #1 chk("flush_req", bus_req, 0);

    // reset in 3rd BUSY cycle, then a late ack
    @(negedge clk);
    valid_m = 1; mem_rd = 1; size = 2; addr = 32'h20; bus_ack = 0;
    #1 chk("rst_mid_acc", stall, 1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1;
    #1 chk("rst_mid_busy", bus_req, 1);
    @(negedge clk);
    reset = 0; valid_m = 0; bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    #1;
    chk("rst_mid_req", bus_req, 0);
    chk("rst_mid_stall", stall, 0);
    @(negedge clk);
    bus_ack = 0;
    #1;
    chk("rst_mid_exc", exc_valid, 0);
    chk("rst_mid_rdata", rdata_w, 0);
    chk("rst_mid_req2", bus_req, 0);
    m_rdata = 0;

    for (int i = 0; i < 60; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sel = $urandom_range(0, 19);
      if (sel < 14)
        a = $urandom_range(0, 32'h7FFF) & ~((32'd1 << sz) - 1);
      else if (sel < 17)
        a = $urandom_range(0, 32'h7FFF);
      else
        a = 32'h8000 + $urandom_range(0, 32'hFFFF);
      an = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      access(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, an, fa,
             $urandom);
    end
    @(negedge clk);
    valid_m = 0;

    acc64(3, 0, 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF,
          64'h0123_4567_89AB_CDEF);
    acc64(2, 0, 32'hC, 64'h1234_5678_0000_0000, 8'hF0,
          64'h0000_0000_1234_5678);
    acc64(0, 1, 32'hF, 64'h80FF_FFFF_FFFF_FFFF, 8'h80,
          64'hFFFF_FFFF_FFFF_FF80);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-stage access unit for the pipelined MIPS core.
- Replaces the single-cycle data-memory path with a variable-latency bus master:
  - issues load/store requests with byte-enables;
  - stalls the pipeline until the bus acknowledges;
  - aligns and extends read data;
  - raises address-error and bus-error/timeout exceptions toward CP0.
- Sits between the M-stage pipeline register and the system bridge.

Parameters:
DATA_W, 32, bus/data width in bits; legal values 32 or 64
ADDR_LO, 32'h0000_0000, lowest legal data address (inclusive)
ADDR_HI, 32'h0000_7FFF, highest legal data address (inclusive)
TIMEOUT_CYC, 16, BUSY cycles without bus_ack before bus-error; legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_m  in  1  M-stage holds a live instruction
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store (mem_rd and mem_wr both high: treated as load)
size  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only)
sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
flush  in  1  exception/eret flush of M stage
addr  in  32  effective address
wdata  in  DATA_W  store data, right-aligned
stall  out  1  freeze F..M pipeline registers
rdata_w  out  DATA_W  aligned/extended load result to W stage
exc_valid  out  1  exception for the current M instruction
exc_code  out  5  4=AdEL, 5=AdES, 7=DBE, 10=RI
bus_req  out  1  bus request, registered
bus_we  out  1  bus write, registered
bus_addr  out  32  word-aligned address (low log2(DATA_W/8) bits zero)
bus_be  out  DATA_W/8  byte enables
bus_wdata  out  DATA_W  lane-shifted store data
bus_ack  in  1  one-cycle transfer completion
bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- Reset values:
  - state=IDLE; stall=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0; rdata_w=0;
  - exc_valid=0; exc_code=0; timeout counter=0.
- Reset mid-transaction:
  - aborts the transaction;
  - bus_req drops the following cycle;
  - a late bus_ack is ignored.
- Request: req = valid_m & (mem_rd|mem_wr) & ~flush.
- Checks (combinational, IDLE only):
  - size=3 with DATA_W=32 -> RI;
  - else misalignment (addr not multiple of 1<<size) or addr outside [ADDR_LO,ADDR_HI] -> AdEL for loads, AdES for stores;
  - RI outranks address errors.
  - On an error: exc_valid=1 in the same cycle; no bus access; stall=0.
- IDLE:
  - on a legal req: latch bus_addr/bus_be/bus_wdata/bus_we, go to BUSY, stall=1 combinationally this cycle.
- BUSY:
  - bus_req=1; stall=1; counter increments each cycle.
  - On bus_ack: latch the aligned rdata (loads), go to DONE, bus_req=0 the next cycle.
  - If the counter reaches TIMEOUT_CYC without ack: go to DONE with pending DBE.
  - bus_ack and timeout in the same cycle: ack wins.
- DONE (exactly one cycle):
  - stall=0; rdata_w valid;
  - exc_valid=1/exc_code=7 if a timeout occurred;
  - next state IDLE unconditionally; M inputs are not re-sampled in DONE.
- flush:
  - blocks acceptance in IDLE;
  - ignored in BUSY (bus transfer always completes, but its result is discarded: no DBE reported, rdata_w unchanged in DONE).
- Byte lanes (offset = addr mod DATA_W/8):
  - bus_be = ((1<<(1<<size))-1) << offset;
  - bus_wdata = wdata << (8*offset).
- Read: field = bus_rdata >> (8*offset), truncated to 8<<size bits, then sign/zero-extended to DATA_W. Word/dword loads ignore sign_ext.
- Minimum latency for a legal access: 3 cycles (accept, BUSY with immediate ack, DONE). Back-to-back accesses are separated by exactly one DONE cycle.
- bus_ack outside BUSY is ignored.

Test Plan:
- LW addr=0x10, bus_ack on 1st BUSY cycle, bus_rdata=0xDEADBEEF -> stall high 2 cycles; DONE: rdata_w=0xDEADBEEF, bus_be=4'hF, exc_valid=0.
- LB sign_ext=1 addr=0x13, rdata=0x80FF_FF7F -> bus_be=4'h8, rdata_w=0xFFFFFF80; with LBU -> 0x00000080.
- SH addr=0x22 wdata=0x0000_1234 -> bus_we=1, bus_be=4'hC, bus_wdata=0x1234_0000; ack after 5 cycles -> stall high 6 cycles total.
- LH addr=0x11 -> exc_valid=1, exc_code=4, no bus_req, stall=0; SW addr=0x8000 -> exc_code=5.
- LW with no ack, TIMEOUT_CYC=16 -> bus_req held 16 cycles, then DONE with exc_code=7, bus_req=0 next cycle.
- Reset asserted in 3rd BUSY cycle -> state IDLE, bus_req=0 next cycle; bus_ack one cycle later produces no DONE. DATA_W=64 LD addr=0x8 -> bus_be=8'hFF.
